// File: rtl/fifo_sync_param_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param_pkg
// Description : Shared definitions for the parametrised single-clock FIFO.
//               Status-flag bit indices (for bundling flags onto a status
//               bus), the default almost-empty level, and a helper that
//               derives the whole flag vector from a fill count.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sync_param_pkg;

    // Bit positions of each flag inside a bundled status vector
    localparam int c_flag_empty   = 0;
    localparam int c_flag_full    = 1;
    localparam int c_flag_afull   = 2;
    localparam int c_flag_aempty  = 3;
    localparam int c_flag_half    = 4;
    localparam int c_flag_healthy = 5;
    localparam int c_flag_num     = 6;

    // Default almost-empty threshold
    localparam int c_def_ae_level = 2;

    // Flag vector while idle after reset or flush: empty and almost empty only
    localparam logic [c_flag_num-1:0] c_flags_reset = 6'b00_1001;

    // Derive all status flags from a fill count
    function automatic logic [c_flag_num-1:0] calc_flags(
        input int unsigned cnt,
        input int unsigned depth,
        input int unsigned af_level,
        input int unsigned ae_level
    );
        logic [c_flag_num-1:0] f;
        f                   = '0;
        f[c_flag_empty]     = (cnt == 0);
        f[c_flag_full]      = (cnt == depth);
        f[c_flag_half]      = (cnt >= depth / 2);
        f[c_flag_afull]     = (cnt >= af_level);
        f[c_flag_aempty]    = (cnt <= ae_level);
        f[c_flag_healthy]   = ~f[c_flag_afull] & ~f[c_flag_aempty];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram_2p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_ram_2p
// Description : Simple dual-port RAM, DATA_W x DEPTH. Synchronous write.
//               Read is synchronous (registered, enabled by i_re) in the
//               default build; with FIFO_FWFT_EN defined the read port is
//               asynchronous so the head word falls through.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset (read register only)
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable (registered-read build)
//               i_raddr  - read address
//               o_rdata  - read data
// Macros      : FIFO_FWFT_EN - asynchronous read port
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram_2p #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Storage is deliberately not reset so it maps onto RAM primitives
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_rdata = r_mem[i_raddr];
`else
    logic [DATA_W-1:0] r_rdata;

    // Read-before-write: a same-edge write to i_raddr returns the old word,
    // which is what a full FIFO doing read+write together relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock FIFO with fill count, registered
//               status flags, programmable almost-full/almost-empty levels,
//               synchronous flush and sticky overflow/underflow bits.
// Ports       : clk, reset (async, active-high)
//               data_in, enable_wr, enable_rd, flush, clr_err   - inputs
//               data_out, data_valid, fill_count                 - outputs
//               f_empty, f_full, f_almost_full, f_almost_empty,
//               f_half, f_healthy                                - status
//               f_overflow, f_underflow                          - sticky errors
// Macros      : FIFO_FWFT_EN - first-word fall-through read port; when
//               undefined, data_out is registered with 1-cycle latency.
// Notes       : DEPTH must be a power of two and at least 4.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 16,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = c_def_ae_level,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enable_wr,
    input  logic              enable_rd,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [AW:0]       fill_count,
    output logic              f_empty,
    output logic              f_full,
    output logic              f_almost_full,
    output logic              f_almost_empty,
    output logic              f_half,
    output logic              f_healthy,
    output logic              f_overflow,
    output logic              f_underflow
);

    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic [c_flag_num-1:0]   r_flags;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic                    w_ram_we;
    logic                    w_ram_re;
    logic                    w_ovf_set;
    logic                    w_udf_set;
    logic [AW:0]             w_count_next;
    logic [c_flag_num-1:0]   w_flags_next;
    logic [DATA_W-1:0]       w_ram_rdata;

    // A full FIFO still takes a write when a read frees a slot on the same
    // edge; an empty FIFO never reads the word being written this cycle.
    assign w_rd_acc = enable_rd & ~r_flags[c_flag_empty];
    assign w_wr_acc = enable_wr & (~r_flags[c_flag_full] | w_rd_acc);

    // Flush swallows the same-cycle transfers
    assign w_ram_we = w_wr_acc & ~flush;
    assign w_ram_re = w_rd_acc & ~flush;

    // Discarded requests under flush are not errors
    assign w_ovf_set = enable_wr & ~w_wr_acc & ~flush;
    assign w_udf_set = enable_rd & ~w_rd_acc & ~flush;

    always_comb begin
        w_count_next = r_count;
        w_flags_next = r_flags;
        if (flush) begin
            w_count_next = '0;
            w_flags_next = c_flags_reset;
        end else begin
            w_count_next = r_count + {{AW{1'b0}}, w_ram_we} - {{AW{1'b0}}, w_ram_re};
            // Flags come from the next count so they line up with fill_count
            w_flags_next = calc_flags(int'(w_count_next), DEPTH, AF_LEVEL, AE_LEVEL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_flags     <= c_flags_reset;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_flags <= w_flags_next;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                // AW-bit pointers wrap naturally since DEPTH is a power of two
                if (w_ram_we) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_ram_re) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Set beats clear when both happen together
            r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
            r_underflow <= w_udf_set | (r_underflow & ~clr_err);
        end
    end

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

`ifdef FIFO_FWFT_EN
    // Head word is presented whenever something is stored; zero otherwise
    assign data_out   = r_flags[c_flag_empty] ? '0 : w_ram_rdata;
    assign data_valid = ~r_flags[c_flag_empty];
`else
    logic r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_ram_re;
        end
    end

    assign data_out   = w_ram_rdata;
    assign data_valid = r_valid;
`endif

    assign fill_count     = r_count;
    assign f_empty        = r_flags[c_flag_empty];
    assign f_full         = r_flags[c_flag_full];
    assign f_almost_full  = r_flags[c_flag_afull];
    assign f_almost_empty = r_flags[c_flag_aempty];
    assign f_half         = r_flags[c_flag_half];
    assign f_healthy      = r_flags[c_flag_healthy];
    assign f_overflow     = r_overflow;
    assign f_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_param
// Description : Directed self-checking bench for fifo_sync_param with
//               DEPTH=8, AF_LEVEL=6, AE_LEVEL=2. Read-data checks adapt to
//               the FIFO_FWFT_EN build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AW     = $clog2(DEPTH);

`ifdef FIFO_FWFT_EN
    localparam bit c_fwft = 1'b1;
`else
    localparam bit c_fwft = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              enable_wr;
    logic              enable_rd;
    logic              flush;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [AW:0]       fill_count;
    logic              f_empty, f_full, f_almost_full, f_almost_empty;
    logic              f_half, f_healthy, f_overflow, f_underflow;

    int total = 0;
    int bad   = 0;

    fifo_sync_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .enable_wr      (enable_wr),
        .enable_rd      (enable_rd),
        .flush          (flush),
        .clr_err        (clr_err),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .fill_count     (fill_count),
        .f_empty        (f_empty),
        .f_full         (f_full),
        .f_almost_full  (f_almost_full),
        .f_almost_empty (f_almost_empty),
        .f_half         (f_half),
        .f_healthy      (f_healthy),
        .f_overflow     (f_overflow),
        .f_underflow    (f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs for one clock, then sample 1 ns after the edge
    task automatic cyc(input logic wr, input logic rd, input logic [DATA_W-1:0] d,
                       input logic fl, input logic ce);
        enable_wr = wr;
        enable_rd = rd;
        data_in   = d;
        flush     = fl;
        clr_err   = ce;
        @(posedge clk);
        #1;
    endtask

    // Pop one word and check it: registered mode shows it after the edge,
    // fall-through mode shows it before the edge.
    task automatic rd_chk(input string tag, input logic [DATA_W-1:0] exp);
        if (c_fwft) begin
            chk({tag, "_head"}, data_out, exp);
            chk({tag, "_valid"}, data_valid, 1);
            cyc(0, 1, 8'h00, 0, 0);
        end else begin
            cyc(0, 1, 8'h00, 0, 0);
            chk({tag, "_data"}, data_out, exp);
            chk({tag, "_valid"}, data_valid, 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        enable_wr = 0; enable_rd = 0; flush = 0; clr_err = 0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_count",  fill_count, 0);
        chk("rst_empty",  f_empty, 1);
        chk("rst_aempty", f_almost_empty, 1);
        chk("rst_full",   f_full, 0);
        chk("rst_healthy", f_healthy, 0);
        chk("rst_valid",  data_valid, 0);
        chk("rst_dout",   data_out, 0);
        chk("rst_ovf",    f_overflow, 0);

        // Three words in, three out
        cyc(1, 0, 8'h0A, 0, 0);
        chk("t1_count1", fill_count, 1);
        cyc(1, 0, 8'h10, 0, 0);
        cyc(1, 0, 8'h41, 0, 0);
        chk("t1_count3",  fill_count, 3);
        chk("t1_healthy", f_healthy, 1);
        chk("t1_empty",   f_empty, 0);
        chk("t1_aempty",  f_almost_empty, 0);
        rd_chk("t1_rd0", 8'h0A);
        chk("t1_count2", fill_count, 2);
        rd_chk("t1_rd1", 8'h10);
        rd_chk("t1_rd2", 8'h41);
        chk("t1_empty_end", f_empty, 1);
        chk("t1_count0", fill_count, 0);
        cyc(0, 0, 8'h00, 0, 0);
        chk("t1_valid_idle", data_valid, 0);
        if (!c_fwft) chk("t1_dout_hold", data_out, 8'h41);

        // Fill to full, overflow, clear
        for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h20 + i), 0, 0);
        chk("t2_full",    f_full, 1);
        chk("t2_half",    f_half, 1);
        chk("t2_afull",   f_almost_full, 1);
        chk("t2_count",   fill_count, 8);
        chk("t2_healthy", f_healthy, 0);
        cyc(1, 0, 8'h99, 0, 0);
        chk("t2_ovf",       f_overflow, 1);
        chk("t2_count_ovf", fill_count, 8);
        cyc(0, 0, 8'h00, 0, 1);
        chk("t2_ovf_clr", f_overflow, 0);

        // Full with read+write together, then drain across the wrap
        if (c_fwft) chk("t3_head_pre", data_out, 8'h20);
        cyc(1, 1, 8'h55, 0, 0);
        chk("t3_count", fill_count, 8);
        chk("t3_ovf",   f_overflow, 0);
        if (c_fwft) begin
            chk("t3_head_post", data_out, 8'h21);
        end else begin
            chk("t3_dout",  data_out, 8'h20);
            chk("t3_valid", data_valid, 1);
        end
        for (int i = 1; i < 8; i++) rd_chk("t3_drain", 8'(8'h20 + i));
        rd_chk("t3_last", 8'h55);
        chk("t3_empty", f_empty, 1);
        chk("t3_udf",   f_underflow, 0);

        // Empty with read+write together
        cyc(1, 1, 8'h66, 0, 0);
        chk("t4_udf",   f_underflow, 1);
        chk("t4_count", fill_count, 1);
        chk("t4_valid", data_valid, c_fwft ? 1 : 0);
        rd_chk("t4_rd", 8'h66);
        chk("t4_count0", fill_count, 0);
        // New underflow together with clr_err keeps the bit set
        cyc(0, 1, 8'h00, 0, 1);
        chk("t4_set_wins", f_underflow, 1);
        cyc(0, 0, 8'h00, 0, 1);
        chk("t4_udf_clr", f_underflow, 0);

        // Flush with a concurrent write
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h70 + i), 0, 0);
        chk("t5_count5", fill_count, 5);
        cyc(1, 0, 8'h77, 1, 0);
        chk("t5_count",  fill_count, 0);
        chk("t5_empty",  f_empty, 1);
        chk("t5_aempty", f_almost_empty, 1);
        chk("t5_half",   f_half, 0);
        chk("t5_ovf",    f_overflow, 0);
        // Post-flush read is an underflow and returns nothing
        cyc(0, 1, 8'h00, 0, 0);
        chk("t5_post_udf", f_underflow, 1);
        chk("t5_post_cnt", fill_count, 0);

        // Asynchronous reset in the middle of a burst
        cyc(1, 0, 8'h31, 0, 0);
        cyc(1, 0, 8'h32, 0, 0);
        cyc(0, 1, 8'h00, 0, 0);
        chk("t6_pre_dout", data_out, c_fwft ? 8'h32 : 8'h31);
        #2 reset = 1'b1;
        #1;
        chk("t6_count", fill_count, 0);
        chk("t6_valid", data_valid, 0);
        chk("t6_dout",  data_out, 0);
        chk("t6_empty", f_empty, 1);
        chk("t6_udf",   f_underflow, 0);
        enable_wr = 0; enable_rd = 0; flush = 0; clr_err = 0;
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef FIFO_FWFT_EN
        // Fall-through: written word appears without a read
        cyc(1, 0, 8'hAA, 0, 0);
        chk("fw_dout",  data_out, 8'hAA);
        chk("fw_valid", data_valid, 1);
        cyc(0, 0, 8'h00, 0, 0);
        chk("fw_hold",  data_out, 8'hAA);
        cyc(0, 1, 8'h00, 0, 0);
        chk("fw_empty", f_empty, 1);
        chk("fw_valid_end", data_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
